btn_cmd_ctrl: RTL
=================

BTN_CMD_CTRL -- requirements
Module: btn_cmd_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of consecutive stable clk cycles needed to accept a new button level.
REQ-002 SHALL have parameter LONG_CYCLES, default 100_000_000, meaning the debounced hold time of btn_run that triggers a clear (used only when BTN_LONG_CLR_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port btn_run, input, 1 bit: raw run/stop push-button, asynchronous, active-high.
REQ-006 SHALL have port btn_clr, input, 1 bit: raw clear push-button, asynchronous, active-high.
REQ-007 SHALL have port btn_mode, input, 1 bit: raw up/down push-button, asynchronous, active-high.
REQ-008 SHALL have port sw0_stp, output, 1 bit: level; 1 = counter stopped, 0 = counting.
REQ-009 SHALL have port sw1_clr, output, 1 bit: registered pulse, exactly one clk cycle wide, to clear the counter.
REQ-010 SHALL have port sw2_inc, output, 1 bit: level; 0 = count up, 1 = count down.

Function
REQ-011 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-012 SHALL hold a debounced level per button and change it only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce back SHALL restart that count at 0.
REQ-013 SHALL generate a press event, one cycle wide, on each 0->1 transition of a debounced level; releases SHALL generate no event.
REQ-014 Press-event latency SHALL be 2 + DEBOUNCE_CYCLES + 1 clk cycles from a stable raw rising edge.
REQ-015 SHALL implement a control FSM with states STOP, RUN and CLEAR.
REQ-016 FSM transitions SHALL be: STOP + run press -> RUN; RUN + run press -> STOP; any state + clr press -> CLEAR; CLEAR -> STOP unconditionally on the next cycle.
REQ-017 sw0_stp SHALL be 0 only in RUN. sw1_clr SHALL be 1 only in CLEAR.
REQ-018 A clr press SHALL take priority over a run press in the same cycle; the run press SHALL then be discarded.
REQ-019 Each mode press SHALL toggle sw2_inc in every FSM state, independently of and simultaneously with FSM events.
REQ-020 Holding a button SHALL never produce more than one press event.

Reset
REQ-021 On rst: FSM = STOP, sw0_stp = 1, sw1_clr = 0, sw2_inc = 0, all synchronizers, debounced levels and counters = 0, all within the same cycle, with no event emitted.
REQ-022 A button held through reset deassertion SHALL produce exactly one press event after the full debounce period.
REQ-023 rst asserted during CLEAR SHALL truncate the pulse immediately.

Configuration
REQ-024 Macro BTN_LONG_CLR_EN defined: a hold counter SHALL run while debounced btn_run = 1; on reaching LONG_CYCLES it SHALL force one CLEAR (-> STOP) and not repeat until release; the toggle from the initial press still occurs first.
REQ-025 Macro BTN_LONG_CLR_EN undefined: there SHALL be no hold counter or LONG_CYCLES logic, and hold duration SHALL be irrelevant.

Structure
REQ-026 Package btn_pkg SHALL hold the FSM state typedef (STOP/RUN/CLEAR encoding) and the default DEBOUNCE_CYCLES and LONG_CYCLES constants.
REQ-027 Sub-module btn_debounce SHALL contain the synchronizer, debounce counter, debounced level and rise-event output, parameterized by DEBOUNCE_CYCLES and instantiated 3 times.
REQ-028 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), and hold counter width SHALL be $clog2(LONG_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Reset release with no buttons -> sw0_stp=1, sw1_clr=0, sw2_inc=0 held for 100 cycles.
REQ-030 btn_run high for 10 cycles -> sw0_stp falls exactly 7 cycles after the raw edge; a second identical press -> sw0_stp=1.
REQ-031 btn_run toggling every 2 cycles for 30 cycles, then held low -> no event, sw0_stp stays 1.
REQ-032 In RUN, btn_clr and btn_run rising on the same cycle -> sw1_clr=1 for exactly 1 cycle, then STOP, sw0_stp=1, no RUN toggle.
REQ-033 Three btn_mode presses of 10 cycles each -> sw2_inc sequence 1,0,1, with FSM state unchanged.
REQ-034 With BTN_LONG_CLR_EN defined, btn_run held for 40 cycles from STOP -> RUN, then one sw1_clr pulse 20 cycles after the debounced rise, then STOP, with no second pulse before release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button command controller.
package btn_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int LONG_CYCLES_DEF     = 100_000_000;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level and
// a one-cycle rise event derived from the debounced level.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      // Any cycle where the input agrees with the level restarts the count.
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Run/stop, clear and up/down command controller driven by three push-buttons.
// Optional macro BTN_LONG_CLR_EN: holding btn_run for LONG_CYCLES forces a clear.
module btn_cmd_ctrl
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clr,
  input  logic btn_mode,
  output logic sw0_stp,
  output logic sw1_clr,
  output logic sw2_inc
);

  logic run_level, clr_level, mode_level;
  logic run_ev, clr_ev, mode_ev;
  logic clr_req;
  state_t state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .rst(rst), .raw(btn_run), .level(run_level), .rise(run_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst(rst), .raw(btn_clr), .level(clr_level), .rise(clr_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level), .rise(mode_ev)
  );

`ifdef BTN_LONG_CLR_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;
  logic          long_ev;

  // Saturating at HOLD_MAX keeps the long-hold clear to one per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (!run_level) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign long_ev = run_level && (hold_cnt == HOLD_LAST);
  assign clr_req = clr_ev | long_ev;
`else
  assign clr_req = clr_ev;
`endif

  // Outputs are registered together with the state; a clear request wins over
  // a run press in the same cycle and the run press is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STOP;
      sw0_stp <= 1'b1;
      sw1_clr <= 1'b0;
      sw2_inc <= 1'b0;
    end else begin
      if (mode_ev) begin
        sw2_inc <= ~sw2_inc;
      end
      if (clr_req) begin
        state   <= CLEAR;
        sw0_stp <= 1'b1;
        sw1_clr <= 1'b1;
      end else begin
        case (state)
          STOP: begin
            sw1_clr <= 1'b0;
            if (run_ev) begin
              state   <= RUN;
              sw0_stp <= 1'b0;
            end
          end
          RUN: begin
            sw1_clr <= 1'b0;
            if (run_ev) begin
              state   <= STOP;
              sw0_stp <= 1'b1;
            end
          end
          CLEAR: begin
            state   <= STOP;
            sw0_stp <= 1'b1;
            sw1_clr <= 1'b0;
          end
          default: begin
            state   <= STOP;
            sw0_stp <= 1'b1;
            sw1_clr <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
